// File: rtl/loop_uhat_sparse_pkg.sv
// Shared constants and types for the sparse u-hat loop multiplier scheduler.
// Holds requester count, operand/product widths, multiplier latency,
// counter width and the requester tag type.
package loop_uhat_sparse_pkg;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned ID_W        = $clog2(NUM_REQ);
  localparam int unsigned DIN0_WIDTH  = 54;
  localparam int unsigned DIN1_WIDTH  = 6;
  localparam int unsigned DOUT_WIDTH  = 54;
  localparam int unsigned MUL_LATENCY = 4;
  localparam int unsigned CNT_W       = 32;

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/loop_uhat_sparse_rr_arb.sv
// Combinational round-robin arbiter.
// Ports:
//   req        per-requester request vector
//   ptr        lane with highest priority this cycle
//   grant      one-hot winner (all zero when nothing requests)
//   idx        encoded winner index (0 when nothing requests)
//   any_grant  at least one requester is asserting req
module loop_uhat_sparse_rr_arb
  import loop_uhat_sparse_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_grant
);

  // Scan upward from ptr, wrapping modulo NUM_REQ; first requester wins.
  always_comb begin
    int unsigned pos;
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    pos       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (32'(ptr) + k) % NUM_REQ;
      if (!any_grant && req[pos[ID_W-1:0]]) begin
        any_grant               = 1'b1;
        grant[pos[ID_W-1:0]]    = 1'b1;
        idx                     = pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/loop_uhat_sparse_mul_sched.sv
// Scheduler sharing one pipelined signed x unsigned multiplier among
// NUM_REQ requesters. Round-robin issue, a valid/tag shadow pipe that
// follows each product through the multiplier, and output backpressure
// that freezes the multiplier through its clock enable.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   per-lane handshake (req_ready is one-hot)
//   req_din0/req_din1     packed per-lane operands
//   mul_ce/mul_din0/1     multiplier controls and operands
//   mul_dout              multiplier product
//   res_valid/res_ready   result handshake; res_id tags the requester
//   res_data              product passed straight from mul_dout
//   idle                  nothing in flight and nothing requesting
//   issued_cnt/stall_cnt  accepted operations / cycles with mul_ce low
module loop_uhat_sparse_mul_sched
  import loop_uhat_sparse_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mul_ce,
  output logic [DIN0_WIDTH-1:0]         mul_din0,
  output logic [DIN1_WIDTH-1:0]         mul_din1,
  input  logic [DOUT_WIDTH-1:0]         mul_dout,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ID_W-1:0]               res_id,
  output logic [DOUT_WIDTH-1:0]         res_data,
  output logic                          idle,
  output logic [CNT_W-1:0]              issued_cnt,
  output logic [CNT_W-1:0]              stall_cnt
);

  logic [NUM_REQ-1:0]     grant;
  req_id_t                win_idx;
  req_id_t                rr_ptr;
  logic                   any_req;
  logic                   xfer;
  logic [MUL_LATENCY-1:0] vld;
  req_id_t                tag [MUL_LATENCY];

  loop_uhat_sparse_rr_arb u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (win_idx),
    .any_grant (any_req)
  );

  assign res_valid = vld[MUL_LATENCY-1];
  assign res_id    = tag[MUL_LATENCY-1];
  assign res_data  = mul_dout;

  // A blocked result freezes the multiplier and the shadow pipe together,
  // so the presented product and its tag stay aligned and stable.
  assign mul_ce    = !(res_valid && !res_ready);
  assign req_ready = (mul_ce && !reset) ? grant : '0;
  assign xfer      = any_req && mul_ce;
  assign idle      = !(|vld) && !(|req_valid);

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (any_req) begin
      mul_din0 = req_din0[32'(win_idx)*DIN0_WIDTH +: DIN0_WIDTH];
      mul_din1 = req_din1[32'(win_idx)*DIN1_WIDTH +: DIN1_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld        <= '0;
      rr_ptr     <= '0;
      issued_cnt <= '0;
      stall_cnt  <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) tag[i] <= '0;
    end else begin
      if (mul_ce) begin
        vld    <= {vld[MUL_LATENCY-2:0], any_req};
        tag[0] <= win_idx;
        for (int unsigned i = 1; i < MUL_LATENCY; i++) tag[i] <= tag[i-1];
      end
      if (xfer) begin
        rr_ptr     <= (win_idx == req_id_t'(NUM_REQ-1)) ? '0 : win_idx + req_id_t'(1);
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      if (!mul_ce) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/loop_uhat_sparse_mul_sched.md
Name: loop_uhat_sparse_mul_sched

Overview:
- Shares one pipelined signed×unsigned multiplier (54s × 6ns → 54, fixed latency) between NUM_REQ requesters in the sparse u-hat loop.
- Round-robin issue; a tag/valid shadow pipeline tracks each product to its requester.
- Backpressure from the result consumer stalls the multiplier through its ce input.
- Sits between the loop's per-lane address/data generators and the multiplier instance. Drives the multiplier's ce/din0/din1 ports and reads its dout.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- ID_W, 2, requester tag width (clog2(NUM_REQ))
- DIN0_WIDTH, 54, signed operand width
- DIN1_WIDTH, 6, unsigned operand width
- DOUT_WIDTH, 54, product width (truncated, two's complement)
- MUL_LATENCY, 4, ce-enabled clock edges from operand presentation to dout
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_din0  in  NUM_REQ*DIN0_WIDTH  signed operands, lane i at [i*DIN0_WIDTH +: DIN0_WIDTH]
- req_din1  in  NUM_REQ*DIN1_WIDTH  unsigned operands, same packing
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  DIN0_WIDTH  operand to multiplier
- mul_din1  out  DIN1_WIDTH  operand to multiplier
- mul_dout  in  DOUT_WIDTH  multiplier product
- res_valid  out  1  result valid
- res_ready  in  1  consumer ready
- res_id  out  ID_W  requester tag of result
- res_data  out  DOUT_WIDTH  product (= mul_dout)
- idle  out  1  no valid entry in shadow pipeline and no req_valid
- issued_cnt  out  CNT_W  accepted operations
- stall_cnt  out  CNT_W  cycles with mul_ce=0

Behaviour:
- Shadow pipe: vld[0..MUL_LATENCY-1], tag[0..MUL_LATENCY-1]. Advances only when mul_ce=1.
- On advance, vld[0] <= any grant and tag[0] <= granted index.
- res_valid = vld[LAT-1]; res_id = tag[LAT-1]; res_data = mul_dout.
- mul_ce = !(res_valid && !res_ready). The whole pipe freezes while the output is blocked, so res_data and res_id are held stable. No bubble collapsing.
- Arbitration (combinational): search from rr_ptr upward, mod NUM_REQ, for the first req_valid.
- req_ready[i] = (winner==i) && mul_ce. At most one bit set.
- On a transfer of lane i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- mul_din0/mul_din1 mux the winner's operands. Both are zero when no lane is requesting.
- Latency: a transfer in cycle t gives res_valid in cycle t+MUL_LATENCY, absent stalls. Each stalled cycle adds one.
- Throughput: one operation per cycle.
- Arithmetic is done by the multiplier: $signed(din0) × zero-extended din1, truncated to DOUT_WIDTH. The scheduler does no width manipulation.
- Counters:
  - issued_cnt increments on each transfer.
  - stall_cnt increments each cycle with mul_ce=0.
  - Both wrap modulo 2^CNT_W.
- Simultaneous events: in the cycle where the output is accepted (res_valid & res_ready), mul_ce=1. A new grant is therefore accepted in that same cycle.
- Reset (async assert, any time):
  - vld all 0, tag all 0, rr_ptr 0, counters 0.
  - Outputs: res_valid 0, res_id 0, req_ready 0, mul_ce 1, idle 1 (if no req_valid).
  - In-flight operations are discarded. The multiplier's internal data is not reset and is masked by vld.
- Requesters must hold req_valid and operands until accepted. The scheduler does not check this.

Decomposition:
- Package loop_uhat_sparse_pkg:
  - constants NUM_REQ, MUL_LATENCY, operand/product widths
  - ID_W derived via clog2
  - typedef for the requester tag
- One sub-module: loop_uhat_sparse_rr_arb. Inputs req vector and ptr; outputs one-hot grant, encoded index and any_grant. Purely combinational.
- Pointer update and shadow pipe stay in the top.

Test Plan:
- Single op, lane 2, din0=-3, din1=5, res_ready=1 → res_valid exactly 4 cycles after the transfer, res_id=2, res_data=-15 (0x3FFFFFFFFFFFF1); issued_cnt=1.
- Unsigned din1: lane 0, din0=-1, din1=6'h3F → res_data=-63.
- All 4 lanes valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; res_id follows the same sequence 4 cycles later, with no bubbles.
- Backpressure: a result pending, res_ready=0 for 3 cycles → res_valid/res_id/res_data held, req_ready=0, mul_ce=0, stall_cnt=3. On release, the next result follows in the next cycle.
- Reset asserted mid-flight with 3 ops in the pipe → res_valid=0 immediately and stays 0 until new issues; rr_ptr back to 0 (lanes 1,3 requesting → lane 1 granted first).
- Pointer skip: only lanes 1 and 3 requesting, rr_ptr=2 → lane 3 granted, then lane 1.
